// File: rtl/score_accumulator_if.sv
// Score accumulator bus: command inputs from the hit/miss judge and the
// score/high-score outputs toward the display driver.
interface score_accumulator_if #(
   parameter int WIDTH      = 8,
   parameter int DWIDTH     = 4,
   parameter int STREAK_MAX = 4
);
   localparam int MW = $clog2(STREAK_MAX + 1);

   logic              CLR;
   logic              LD;
   logic              SUB;
   logic              MISS;
   logic [DWIDTH-1:0] D;
   logic [WIDTH-1:0]  Q;
   logic [WIDTH-1:0]  HI;
   logic [MW-1:0]     MULT;
   logic              OVF;
   logic              NEW_HI;

   // Judge side: issues commands, observes score state.
   modport master (
      output CLR, LD, SUB, MISS, D,
      input  Q, HI, MULT, OVF, NEW_HI
   );

   // Accumulator side: consumes commands, drives score state.
   modport slave (
      input  CLR, LD, SUB, MISS, D,
      output Q, HI, MULT, OVF, NEW_HI
   );
endinterface

// File: rtl/score_accumulator.sv
// Player-score accumulator: streak-multiplied hits, floored penalties,
// saturate-or-wrap overflow and a session high score that survives restarts.
module score_accumulator #(
   parameter int WIDTH      = 8,
   parameter int DWIDTH     = 4,
   parameter bit SATURATE   = 1'b1,
   parameter int STREAK_LEN = 3,
   parameter int STREAK_MAX = 4
) (
   input logic                clk,
   input logic                CLR_n,
   score_accumulator_if.slave bus
);
   localparam int MW = $clog2(STREAK_MAX + 1);
   localparam int CW = $clog2(STREAK_LEN + 1);
   localparam int GW = DWIDTH + MW;
   localparam int SW = ((WIDTH > GW) ? WIDTH : GW) + 1;

   localparam logic [MW-1:0]    MULT_ONE = MW'(1);
   localparam logic [MW-1:0]    MULT_TOP = MW'(STREAK_MAX);
   localparam logic [CW-1:0]    HITS_TOP = CW'(STREAK_LEN);
   localparam logic [WIDTH-1:0] Q_MAX    = {WIDTH{1'b1}};

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [MW-1:0]    mult_q, mult_d;
   logic [CW-1:0]    hits_q, hits_d;
   logic             ovf_q, ovf_d;
   logic             new_hi_q, new_hi_d;

   logic [GW-1:0]    gain_s;
   logic [SW-1:0]    sum_s;
   logic [CW-1:0]    hits_inc_s;

   // Next-state: command priority CLR > SUB > LD > MISS, plus high-score compare.
   always_comb begin
      q_d        = q_q;
      hi_d       = hi_q;
      mult_d     = mult_q;
      hits_d     = hits_q;
      ovf_d      = ovf_q;
      new_hi_d   = 1'b0;
      gain_s     = GW'(bus.D) * GW'(mult_q);
      sum_s      = SW'(q_q) + SW'(gain_s);
      hits_inc_s = hits_q + CW'(1);

      // High score tracks the registered score one cycle later; a restart
      // edge leaves it untouched.
      if (bus.CLR) begin
         new_hi_d = 1'b0;
      end else if (q_q > hi_q) begin
         hi_d     = q_q;
         new_hi_d = 1'b1;
      end else begin
         new_hi_d = 1'b0;
      end

      if (bus.CLR) begin
         q_d    = {WIDTH{1'b0}};
         ovf_d  = 1'b0;
         mult_d = MULT_ONE;
         hits_d = {CW{1'b0}};
      end else if (bus.SUB) begin
         // Penalty floors at zero instead of underflowing.
         if (SW'(q_q) >= SW'(bus.D)) begin
            q_d = q_q - WIDTH'(bus.D);
         end else begin
            q_d = {WIDTH{1'b0}};
         end
         mult_d = MULT_ONE;
         hits_d = {CW{1'b0}};
      end else if (bus.LD) begin
         if (|sum_s[SW-1:WIDTH]) begin
            ovf_d = 1'b1;
            q_d   = SATURATE ? Q_MAX : sum_s[WIDTH-1:0];
         end else begin
            q_d = sum_s[WIDTH-1:0];
         end
         // Each completed streak bumps the multiplier up to its ceiling.
         if (hits_inc_s == HITS_TOP) begin
            hits_d = {CW{1'b0}};
            if (mult_q < MULT_TOP) begin
               mult_d = mult_q + MW'(1);
            end else begin
               mult_d = mult_q;
            end
         end else begin
            hits_d = hits_inc_s;
         end
      end else if (bus.MISS) begin
         mult_d = MULT_ONE;
         hits_d = {CW{1'b0}};
      end else begin
         q_d = q_q;
      end
   end

   // State registers with synchronous active-low session reset.
   always_ff @(posedge clk) begin
      if (!CLR_n) begin
         q_q      <= {WIDTH{1'b0}};
         hi_q     <= {WIDTH{1'b0}};
         mult_q   <= MULT_ONE;
         hits_q   <= {CW{1'b0}};
         ovf_q    <= 1'b0;
         new_hi_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         hi_q     <= hi_d;
         mult_q   <= mult_d;
         hits_q   <= hits_d;
         ovf_q    <= ovf_d;
         new_hi_q <= new_hi_d;
      end
   end

   assign bus.Q      = q_q;
   assign bus.HI     = hi_q;
   assign bus.MULT   = mult_q;
   assign bus.OVF    = ovf_q;
   assign bus.NEW_HI = new_hi_q;
endmodule

// File: tb/tb_score_accumulator.sv
// Bench for score_accumulator: a saturating and a wrapping instance driven
// with identical stimulus, checked by directed vectors and a reference model.
module tb_score_accumulator;
   logic clk = 1'b0;
   logic clr_n = 1'b0;

   always #5 clk = ~clk;

   score_accumulator_if #(.WIDTH(8), .DWIDTH(4), .STREAK_MAX(4)) if_s ();
   score_accumulator_if #(.WIDTH(8), .DWIDTH(4), .STREAK_MAX(4)) if_w ();

   score_accumulator #(.WIDTH(8), .DWIDTH(4), .SATURATE(1'b1),
                       .STREAK_LEN(3), .STREAK_MAX(4))
      dut_s (.clk(clk), .CLR_n(clr_n), .bus(if_s));
   score_accumulator #(.WIDTH(8), .DWIDTH(4), .SATURATE(1'b0),
                       .STREAK_LEN(3), .STREAK_MAX(4))
      dut_w (.clk(clk), .CLR_n(clr_n), .bus(if_w));

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = saturating, 1 = wrapping.
   int m_q[2], m_hi[2], m_mult[2], m_hits[2], m_ovf[2], m_nh[2];

   typedef struct {
      bit rn, clr, ld, sub, miss;
      int d;
      int q, hi, mult, ovf, nh;
   } vec_t;

   vec_t tbl[27];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input int m, input bit rn, input bit clr, input bit ld,
                             input bit sub, input bit miss, input int d);
      int s;
      if (!rn) begin
         m_q[m] = 0; m_hi[m] = 0; m_mult[m] = 1; m_hits[m] = 0; m_ovf[m] = 0; m_nh[m] = 0;
      end else begin
         // High score follows the score as it stood before this edge.
         if (clr) m_nh[m] = 0;
         else if (m_q[m] > m_hi[m]) begin m_hi[m] = m_q[m]; m_nh[m] = 1; end
         else m_nh[m] = 0;

         if (clr) begin
            m_q[m] = 0; m_ovf[m] = 0; m_mult[m] = 1; m_hits[m] = 0;
         end else if (sub) begin
            m_q[m] = (m_q[m] >= d) ? m_q[m] - d : 0;
            m_mult[m] = 1; m_hits[m] = 0;
         end else if (ld) begin
            s = m_q[m] + d * m_mult[m];
            if (s > 255) begin
               m_ovf[m] = 1;
               m_q[m] = (m == 0) ? 255 : s % 256;
            end else m_q[m] = s;
            m_hits[m]++;
            if (m_hits[m] == 3) begin
               m_hits[m] = 0;
               if (m_mult[m] < 4) m_mult[m]++;
            end
         end else if (miss) begin
            m_mult[m] = 1; m_hits[m] = 0;
         end
      end
   endtask

   task automatic apply(input bit rn, input bit clr, input bit ld,
                        input bit sub, input bit miss, input int d);
      clr_n = rn;
      if_s.CLR = clr; if_s.LD = ld; if_s.SUB = sub; if_s.MISS = miss; if_s.D = 4'(d);
      if_w.CLR = clr; if_w.LD = ld; if_w.SUB = sub; if_w.MISS = miss; if_w.D = 4'(d);
      @(posedge clk);
      #1;
      model_step(0, rn, clr, ld, sub, miss, d);
      model_step(1, rn, clr, ld, sub, miss, d);
   endtask

   task automatic check_models();
      chk("q_sat",    int'(if_s.Q),      m_q[0]);
      chk("hi_sat",   int'(if_s.HI),     m_hi[0]);
      chk("mult_sat", int'(if_s.MULT),   m_mult[0]);
      chk("ovf_sat",  int'(if_s.OVF),    m_ovf[0]);
      chk("nh_sat",   int'(if_s.NEW_HI), m_nh[0]);
      chk("q_wrap",   int'(if_w.Q),      m_q[1]);
      chk("hi_wrap",  int'(if_w.HI),     m_hi[1]);
      chk("mult_wrap",int'(if_w.MULT),   m_mult[1]);
      chk("ovf_wrap", int'(if_w.OVF),    m_ovf[1]);
      chk("nh_wrap",  int'(if_w.NEW_HI), m_nh[1]);
   endtask

   initial begin
      //              rn clr ld sub miss d     q   hi mult ovf nh
      tbl[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 9,    0,   0, 1, 0, 0};
      tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,    5,   0, 1, 0, 0};
      tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   10,   5, 1, 0, 1};
      tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   15,  10, 2, 0, 1};
      tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   25,  15, 2, 0, 1};
      tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 0,   25,  25, 2, 0, 1};
      tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 0,   25,  25, 2, 0, 0};
      tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   35,  25, 2, 0, 0};
      tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   45,  35, 3, 0, 1};
      tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   60,  45, 3, 0, 1};
      tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   75,  60, 3, 0, 1};
      tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,   90,  75, 4, 0, 1};
      tbl[12] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,  110,  90, 4, 0, 1};
      tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,  130, 110, 4, 0, 1};
      tbl[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,  150, 130, 4, 0, 1};
      tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 0,  150, 150, 4, 0, 1};
      tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 0,  150, 150, 1, 0, 0};
      tbl[17] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5,  155, 150, 1, 0, 0};
      tbl[18] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 2,  157, 155, 1, 0, 1};
      tbl[19] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 2,  159, 157, 2, 0, 1};
      tbl[20] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 2,  163, 159, 2, 0, 1};
      tbl[21] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 7,    0, 159, 1, 0, 0};
      tbl[22] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10,   10, 159, 1, 0, 0};
      tbl[23] = '{1'b1,1'b0,1'b0,1'b1,1'b0,15,    0, 159, 1, 0, 0};
      tbl[24] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10,   10, 159, 1, 0, 0};
      tbl[25] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10,   20, 159, 1, 0, 0};
      tbl[26] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 3,   17, 159, 1, 0, 0};

      foreach (m_q[m]) begin
         m_q[m] = 0; m_hi[m] = 0; m_mult[m] = 1; m_hits[m] = 0; m_ovf[m] = 0; m_nh[m] = 0;
      end

      // Directed vectors: reset, streak build, streak break, penalty, collisions.
      for (int i = 0; i < 27; i++) begin
         apply(tbl[i].rn, tbl[i].clr, tbl[i].ld, tbl[i].sub, tbl[i].miss, tbl[i].d);
         chk($sformatf("tbl%0d_q", i),    int'(if_s.Q),      tbl[i].q);
         chk($sformatf("tbl%0d_hi", i),   int'(if_s.HI),     tbl[i].hi);
         chk($sformatf("tbl%0d_mult", i), int'(if_s.MULT),   tbl[i].mult);
         chk($sformatf("tbl%0d_ovf", i),  int'(if_s.OVF),    tbl[i].ovf);
         chk($sformatf("tbl%0d_nh", i),   int'(if_s.NEW_HI), tbl[i].nh);
      end

      // Overflow: reach 250 at MULT=1, then add 15 in both modes.
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int k = 0; k < 8; k++) begin
         apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15);
         apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15);
         apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      end
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10);
      chk("ovf_pre_q_sat",  int'(if_s.Q), 250);
      chk("ovf_pre_q_wrap", int'(if_w.Q), 250);
      chk("ovf_pre_mult",   int'(if_s.MULT), 1);
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15);
      chk("ovf_q_sat",   int'(if_s.Q),   255);
      chk("ovf_flag_sat",int'(if_s.OVF), 1);
      chk("ovf_q_wrap",  int'(if_w.Q),   9);
      chk("ovf_flag_wrap",int'(if_w.OVF),1);
      chk("ovf_hi_wrap", int'(if_w.HI),  250);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("ovf_hi_sat",      int'(if_s.HI),     255);
      chk("ovf_nh_sat",      int'(if_s.NEW_HI), 1);
      chk("ovf_hi_wrap_hold",int'(if_w.HI),     250);
      chk("ovf_nh_wrap",     int'(if_w.NEW_HI), 0);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("clr_q_sat",   int'(if_s.Q),    0);
      chk("clr_ovf_sat", int'(if_s.OVF),  0);
      chk("clr_hi_sat",  int'(if_s.HI),   255);
      chk("clr_mult_sat",int'(if_s.MULT), 1);
      chk("clr_hi_wrap", int'(if_w.HI),   250);
      chk("clr_ovf_wrap",int'(if_w.OVF),  0);

      // Session reset in the middle of a streak with HI=40.
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10);
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("rst_pre_hi",   int'(if_s.HI),   40);
      chk("rst_pre_mult", int'(if_s.MULT), 2);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9);
      chk("rst_q",    int'(if_s.Q),      0);
      chk("rst_hi",   int'(if_s.HI),     0);
      chk("rst_mult", int'(if_s.MULT),   1);
      chk("rst_nh",   int'(if_s.NEW_HI), 0);
      chk("rst_ovf",  int'(if_s.OVF),    0);
      chk("rst_hi_wrap", int'(if_w.HI),  0);

      // Randomised commands against the reference model, both modes.
      for (int n = 0; n < 600; n++) begin
         apply($urandom_range(0, 99) != 0,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0,
               int'($urandom_range(0, 15)));
         check_models();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
